floating_point_divider: RTL

Multi-cycle IEEE-754 single-precision divider computing `quotient = dividend / divisor`. It is the general two-operand counterpart to the combinational reciprocal unit, and is used wherever a true a/b result is needed without a reciprocal-then-multiply round trip. The mantissa is computed by restoring division at one quotient bit per cycle, behind valid/ready handshakes on both sides.

---
 rtl/fp32_pkg.sv | 23 ++
 rtl/floating_point_divider_if.sv | 24 ++
 rtl/fp_restoring_div_step.sv | 17 +
 rtl/floating_point_divider.sv | 134 +++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared fp32 definitions: field layout, format constants and divider FSM states.
package fp32_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] frac;
  } fp32_t;

  localparam int          FP32_BIAS    = 127;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  FP32_EXP_MAX = 8'hFF;

  // Index of the first (most significant) quotient bit produced by the divider.
  localparam logic [4:0]  DIV_FIRST_BIT = 5'd24;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_DIVIDE,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/floating_point_divider_if.sv
// Operand/result handshake bundle of the fp32 divider.
interface floating_point_divider_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient
  );

  // Divider side.
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient
  );

endinterface

// File: rtl/fp_restoring_div_step.sv
// One restoring-division step: compare partial remainder with divisor,
// emit one quotient bit and the shifted next remainder.
module fp_restoring_div_step (
  input  logic [24:0] r,
  input  logic [23:0] mb,
  output logic        q_bit,
  output logic [24:0] r_next
);

  logic [24:0] w_diff;

  // The remainder always stays below 2*mb, so the shifted result fits in 25 bits.
  assign w_diff = r - {1'b0, mb};
  assign q_bit  = (r >= {1'b0, mb});
  assign r_next = q_bit ? (w_diff << 1) : (r << 1);

endmodule

// File: rtl/floating_point_divider.sv
// Multi-cycle fp32 divider: one quotient bit per cycle by restoring division,
// truncating rounding, denormals flushed to zero.
module floating_point_divider
  import fp32_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  floating_point_divider_if.slave  bus
);

  div_state_t         r_state;
  div_state_t         w_state_next;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [23:0]        r_mb;
  logic [24:0]        r_rem;
  logic [23:0]        r_q;
  logic [4:0]         r_k;
  logic [31:0]        r_quot;

  fp32_t              w_a;
  fp32_t              w_b;
  logic               w_sign;
  logic               w_accept;
  logic               w_special;
  logic [31:0]        w_special_res;
  logic               w_q_bit;
  logic [24:0]        w_r_next;
  logic [24:0]        w_q_full;
  logic signed [9:0]  w_exp_norm;
  logic [22:0]        w_mant;
  logic [31:0]        w_norm_res;

  assign w_a       = bus.dividend;
  assign w_b       = bus.divisor;
  assign w_sign    = w_a.sign ^ w_b.sign;
  assign w_accept  = bus.in_valid && (r_state == DIV_IDLE);
  assign w_special = (w_a.exp == FP32_EXP_MAX) || (w_b.exp == FP32_EXP_MAX) ||
                     (w_a.exp == 8'd0) || (w_b.exp == 8'd0);

  assign bus.in_ready  = (r_state == DIV_IDLE);
  assign bus.out_valid = (r_state == DIV_DONE);
  assign bus.quotient  = r_quot;

  fp_restoring_div_step u_step (
    .r      (r_rem),
    .mb     (r_mb),
    .q_bit  (w_q_bit),
    .r_next (w_r_next)
  );

  // Quotient including the bit resolved this cycle (complete when r_k == 0).
  assign w_q_full   = {r_q, w_q_bit};
  assign w_exp_norm = r_exp + (w_q_full[24] ? 10'sd127 : 10'sd126);
  assign w_mant     = w_q_full[24] ? w_q_full[23:1] : w_q_full[22:0];

  // Special-operand result: NaN/Inf inputs first, then divide-by-zero, then zero dividend.
  always_comb begin
    w_special_res = {w_sign, 31'b0};
    if ((w_a.exp == FP32_EXP_MAX) || (w_b.exp == FP32_EXP_MAX)) begin
      w_special_res = FP32_QNAN;
    end else if (w_b.exp == 8'd0) begin
      w_special_res = {w_sign, FP32_EXP_MAX, 23'b0};
    end
  end

  // Normalised result with overflow to Inf and underflow to zero.
  always_comb begin
    w_norm_res = {r_sign, w_exp_norm[7:0], w_mant};
    if (w_exp_norm >= 10'sd255) begin
      w_norm_res = {r_sign, FP32_EXP_MAX, 23'b0};
    end else if (w_exp_norm <= 10'sd0) begin
      w_norm_res = {r_sign, 31'b0};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DIV_IDLE:   if (w_accept) w_state_next = w_special ? DIV_DONE : DIV_DIVIDE;
      DIV_DIVIDE: if (r_k == 5'd0) w_state_next = DIV_DONE;
      DIV_DONE:   if (bus.out_ready) w_state_next = DIV_IDLE;
      default:    w_state_next = DIV_IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate the step, capture the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign <= 1'b0;
      r_exp  <= '0;
      r_mb   <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_k    <= '0;
      r_quot <= '0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (w_accept) begin
            r_sign <= w_sign;
            if (w_special) begin
              r_quot <= w_special_res;
            end else begin
              r_exp <= $signed({2'b00, w_a.exp}) - $signed({2'b00, w_b.exp});
              r_mb  <= {1'b1, w_b.frac};
              r_rem <= {2'b01, w_a.frac};
              r_q   <= '0;
              r_k   <= DIV_FIRST_BIT;
            end
          end
        end
        DIV_DIVIDE: begin
          r_rem <= w_r_next;
          r_q   <= w_q_full[23:0];
          r_k   <= r_k - 5'd1;
          if (r_k == 5'd0) r_quot <= w_norm_res;
        end
        default: ;
      endcase
    end
  end

endmodule
